div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative integer divide execution unit; the responder on the generic reservation station's execution-unit handshake.
- Accepts one operand pair plus RS entry index from the RS, computes DIV/DIVU/REM/REMU (RV64, XLEN from len5_pkg) with a radix-2 restoring algorithm, and returns the result tagged with the same entry index.
- The RS then forwards the result to the CDB.

Parameters:
- RS_DEPTH, 4, depth of the issuing RS (power of 2); sets entry index width $clog2(RS_DEPTH).
- EU_CTL_LEN, 2, width of the operation control field.
- EXCEPT_LEN, 2, width of the exception code field.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset; asynchronous and active-low.
- flush_i  in  1  synchronous pipeline flush.
- eu_valid_i  in  1  RS presents a ready-to-execute operation.
- eu_ready_o  out  1  unit can accept an operation.
- eu_ctl_i  in  EU_CTL_LEN  encoding: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- eu_rs1_i  in  XLEN  dividend.
- eu_rs2_i  in  XLEN  divisor.
- eu_entry_idx_i  in  $clog2(RS_DEPTH)  RS entry tag.
- eu_valid_o  out  1  result valid.
- eu_ready_i  in  1  RS accepts the result.
- eu_entry_idx_o  out  $clog2(RS_DEPTH)  tag of the result.
- eu_result_o  out  XLEN  quotient or remainder.
- eu_except_raised_o  out  1  exception flag; tied 0 (RISC-V divide never traps).
- eu_except_code_o  out  EXCEPT_LEN  tied 0.

Behaviour:
- FSM states: IDLE, CALC, DONE. Reset: state IDLE, eu_valid_o=0, eu_entry_idx_o=0, eu_result_o=0, counter=0, all datapath registers 0.
- eu_ready_o=1 only in IDLE. Accept = eu_valid_i & eu_ready_o at a rising edge. On accept, capture ctl, entry index and operands.
- Signed ops (ctl[0]=0):
  - Take absolute values of both operands; record neg_q = sign(rs1) XOR sign(rs2) and neg_r = sign(rs1).
  - After the unsigned divide, negate the quotient if neg_q and the remainder if neg_r.
- Special cases, detected at accept; go IDLE->DONE directly (result valid 1 cycle after accept edge):
  - Divisor 0: quotient = all ones; remainder = rs1.
  - Signed overflow (rs1 = 0x8000_0000_0000_0000, rs2 = -1): quotient = rs1; remainder = 0.
- Normal path:
  - IDLE->CALC on accept. CALC runs exactly XLEN cycles, one quotient bit per cycle, with counter decrementing XLEN-1..0.
  - Each cycle: partial remainder = {rem, dividend MSB}; if partial >= divisor, subtract and shift in quotient bit 1, else shift in 0.
  - Counter==0 in CALC -> DONE. The sign fix and quotient/remainder select are registered into eu_result_o on this transition.
  - Result valid XLEN+1 cycles after the accept edge.
- DONE: eu_valid_o=1, and eu_result_o/eu_entry_idx_o held stable until eu_ready_i=1. On that edge -> IDLE, eu_valid_o=0. No back-to-back overlap: the next accept is earliest the cycle after returning to IDLE.
- flush_i (any state) -> IDLE at the next edge; eu_valid_o=0; in-flight operation discarded. flush_i has priority over accept and over result handshake in the same cycle.
- Asynchronous reset mid-CALC or mid-DONE: immediately IDLE, outputs at reset values, no result emitted.
- eu_valid_i while not in IDLE is ignored (RS must hold it).

Test Plan:
- DIVU rs1=100, rs2=7, idx=2 -> eu_valid_o rises 65 cycles after accept with result 14, idx 2; REMU same operands -> 2.
- DIV rs1=-100, rs2=7 -> -14 (0xFFFF_FFFF_FFFF_FFF2); REM -> -2; REM rs1=100, rs2=-7 -> 2.
- Divide by zero: DIVU 5/0 -> 0xFFFF_FFFF_FFFF_FFFF after 1 cycle; REM 5/0 -> 5.
- Overflow DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM -> 0; latency 1 cycle.
- Backpressure: hold eu_ready_i=0 for 10 cycles in DONE -> result and idx stable and eu_ready_o=0; release -> IDLE, eu_ready_o=1 the next cycle.
- flush_i asserted at CALC cycle 30 -> no eu_valid_o ever for that op; new DIVU 9/3 accepted the cycle after -> result 3. Repeat with rst_n_i pulsed low mid-CALC -> outputs zero immediately.

Source files
------------

// File: rtl/div_unit.sv
// Radix-2 restoring divider (DIV/DIVU/REM/REMU) answering the RS execution-unit handshake.
// Latency: XLEN+1 cycles from accept to eu_valid_o for a normal divide, 1 cycle for divide-by-zero and signed overflow.
// Backpressure: one operation in flight; eu_ready_o only in IDLE, and the result is held in DONE until eu_ready_i.
module div_unit #(
    parameter int XLEN       = 64,
    parameter int RS_DEPTH   = 4,
    parameter int EU_CTL_LEN = 2,
    parameter int EXCEPT_LEN = 2,
    localparam int IDX_W     = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1,
    localparam int CNT_W     = $clog2(XLEN)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  eu_valid_i,
    output logic                  eu_ready_o,
    input  logic [EU_CTL_LEN-1:0] eu_ctl_i,
    input  logic [XLEN-1:0]       eu_rs1_i,
    input  logic [XLEN-1:0]       eu_rs2_i,
    input  logic [IDX_W-1:0]      eu_entry_idx_i,
    output logic                  eu_valid_o,
    input  logic                  eu_ready_i,
    output logic [IDX_W-1:0]      eu_entry_idx_o,
    output logic [XLEN-1:0]       eu_result_o,
    output logic                  eu_except_raised_o,
    output logic [EXCEPT_LEN-1:0] eu_except_code_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_sel_rem;   // 1: return remainder, 0: return quotient
    logic              r_neg_q;
    logic              r_neg_r;
    logic [IDX_W-1:0]  r_idx;
    logic [XLEN-1:0]   r_dvd;       // dividend shifting out, quotient shifting in
    logic [XLEN-1:0]   r_dvsr;
    logic [XLEN-1:0]   r_rem;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_result;

    logic              w_idle;
    logic              w_accept;
    logic              w_signed;
    logic              w_rs1_neg;
    logic              w_rs2_neg;
    logic [XLEN-1:0]   w_abs1;
    logic [XLEN-1:0]   w_abs2;
    logic              w_div_zero;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;
    logic [XLEN:0]     w_partial;
    logic [XLEN:0]     w_diff;
    logic              w_ge;
    logic [XLEN-1:0]   w_rem_nxt;
    logic [XLEN-1:0]   w_dvd_nxt;
    logic [XLEN-1:0]   w_quot_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_final;

    assign w_idle   = (r_state == S_IDLE);
    // flush wins over a simultaneous accept
    assign w_accept = eu_valid_i & w_idle & ~flush_i;

    // Operand preparation and special-case detection on the incoming pair
    assign w_signed      = ~eu_ctl_i[0];
    assign w_rs1_neg     = w_signed & eu_rs1_i[XLEN-1];
    assign w_rs2_neg     = w_signed & eu_rs2_i[XLEN-1];
    assign w_abs1        = w_rs1_neg ? -eu_rs1_i : eu_rs1_i;
    assign w_abs2        = w_rs2_neg ? -eu_rs2_i : eu_rs2_i;
    assign w_div_zero    = (eu_rs2_i == '0);
    assign w_ovf         = w_signed & (eu_rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (eu_rs2_i == '1);
    assign w_special     = w_div_zero | w_ovf;
    assign w_special_res = w_div_zero ? (eu_ctl_i[1] ? eu_rs1_i : '1)
                                      : (eu_ctl_i[1] ? '0 : eu_rs1_i);

    // One restoring step: a borrow out of the trial subtraction means partial < divisor
    assign w_partial  = {r_rem, r_dvd[XLEN-1]};
    assign w_diff     = w_partial - {1'b0, r_dvsr};
    assign w_ge       = ~w_diff[XLEN];
    assign w_rem_nxt  = w_ge ? w_diff[XLEN-1:0] : w_partial[XLEN-1:0];
    assign w_dvd_nxt  = {r_dvd[XLEN-2:0], w_ge};
    assign w_quot_fix = r_neg_q ? -w_dvd_nxt : w_dvd_nxt;
    assign w_rem_fix  = r_neg_r ? -w_rem_nxt : w_rem_nxt;
    assign w_final    = r_sel_rem ? w_rem_fix : w_quot_fix;

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        eu_ready_o  = 1'b0;
        eu_valid_o  = 1'b0;
        case (r_state)
            S_IDLE: begin
                eu_ready_o = 1'b1;
                if (w_accept) w_state_nxt = w_special ? S_DONE : S_CALC;
            end
            S_CALC: begin
                if (r_cnt == '0) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                eu_valid_o = 1'b1;
                if (eu_ready_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush_i) w_state_nxt = S_IDLE;
    end

    // Datapath: capture on accept, iterate in CALC, register the sign-fixed result on the last step
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sel_rem <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_idx     <= '0;
            r_dvd     <= '0;
            r_dvsr    <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
        end else if (w_accept) begin
            r_sel_rem <= eu_ctl_i[1];
            r_neg_q   <= w_rs1_neg ^ w_rs2_neg;
            r_neg_r   <= w_rs1_neg;
            r_idx     <= eu_entry_idx_i;
            r_dvd     <= w_abs1;
            r_dvsr    <= w_abs2;
            r_rem     <= '0;
            r_cnt     <= CNT_W'(XLEN - 1);
            if (w_special) r_result <= w_special_res;
        end else if ((r_state == S_CALC) && !flush_i) begin
            r_dvd <= w_dvd_nxt;
            r_rem <= w_rem_nxt;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == '0) r_result <= w_final;
        end
    end

    assign eu_entry_idx_o     = r_idx;
    assign eu_result_o        = r_result;
    assign eu_except_raised_o = 1'b0;
    assign eu_except_code_o   = '0;

endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized checks of div_unit against an arithmetic reference model.
// Latency is counted in rising edges from the accept edge (inclusive) to first sight of eu_valid_o.
// Inputs are driven and outputs sampled on the falling edge.
module tb_div_unit;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        eu_valid_i = 1'b0;
    logic        eu_ready_o;
    logic [1:0]  eu_ctl_i = '0;
    logic [63:0] eu_rs1_i = '0;
    logic [63:0] eu_rs2_i = '0;
    logic [1:0]  eu_entry_idx_i = '0;
    logic        eu_valid_o;
    logic        eu_ready_i = 1'b1;
    logic [1:0]  eu_entry_idx_o;
    logic [63:0] eu_result_o;
    logic        eu_except_raised_o;
    logic [1:0]  eu_except_code_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    div_unit #(.XLEN(64), .RS_DEPTH(4), .EU_CTL_LEN(2), .EXCEPT_LEN(2)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .eu_valid_i(eu_valid_i), .eu_ready_o(eu_ready_o), .eu_ctl_i(eu_ctl_i),
        .eu_rs1_i(eu_rs1_i), .eu_rs2_i(eu_rs2_i), .eu_entry_idx_i(eu_entry_idx_i),
        .eu_valid_o(eu_valid_o), .eu_ready_i(eu_ready_i), .eu_entry_idx_o(eu_entry_idx_o),
        .eu_result_o(eu_result_o), .eu_except_raised_o(eu_except_raised_o),
        .eu_except_code_o(eu_except_code_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic is_special(input logic [1:0] ctl, input logic [63:0] a, input logic [63:0] b);
        return (b == 64'd0) || (!ctl[0] && a == MIN64 && b == ONES);
    endfunction

    // RISC-V divide semantics using native 64-bit arithmetic (truncating toward zero)
    function automatic logic [63:0] ref_div(input logic [1:0] ctl, input logic [63:0] a, input logic [63:0] b);
        longint sa, sb;
        sa = a;
        sb = b;
        if (b == 64'd0) return ctl[1] ? a : ONES;
        if (!ctl[0] && a == MIN64 && b == ONES) return ctl[1] ? 64'd0 : a;
        case (ctl)
            2'b00:   return 64'(sa / sb);
            2'b01:   return a / b;
            2'b10:   return 64'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    task automatic start_op(input logic [1:0] ctl, input logic [63:0] a, input logic [63:0] b,
                            input logic [1:0] idx, input logic rdy);
        @(negedge clk_i);
        chk("ready_before_accept", 64'(eu_ready_o), 64'd1);
        eu_valid_i = 1'b1; eu_ctl_i = ctl; eu_rs1_i = a; eu_rs2_i = b;
        eu_entry_idx_i = idx; eu_ready_i = rdy;
        @(negedge clk_i);
        eu_valid_i = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] ctl, input logic [63:0] a, input logic [63:0] b,
                          input logic [1:0] idx, input int hold);
        logic [63:0] exp;
        int exp_lat, lat;
        exp     = ref_div(ctl, a, b);
        exp_lat = is_special(ctl, a, b) ? 1 : 65;
        start_op(ctl, a, b, idx, hold == 0);
        lat = 1;
        while (!eu_valid_o && lat < 200) begin
            chk("ready_low_busy", 64'(eu_ready_o), 64'd0);
            @(negedge clk_i);
            lat++;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("result", eu_result_o, exp);
        chk("idx", 64'(eu_entry_idx_o), 64'(idx));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            chk("hold_valid", 64'(eu_valid_o), 64'd1);
            chk("hold_result", eu_result_o, exp);
            chk("hold_idx", 64'(eu_entry_idx_o), 64'(idx));
            chk("hold_ready_o", 64'(eu_ready_o), 64'd0);
        end
        eu_ready_i = 1'b1;
        @(negedge clk_i);
        chk("valid_drop", 64'(eu_valid_o), 64'd0);
        chk("idle_ready", 64'(eu_ready_o), 64'd1);
    endtask

    initial begin
        logic [1:0]  rc;
        logic [63:0] ra, rb;
        int          seen, wait_cnt;

        // Reset state
        #2;
        chk("rst_valid", 64'(eu_valid_o), 64'd0);
        chk("rst_result", eu_result_o, 64'd0);
        chk("rst_idx", 64'(eu_entry_idx_o), 64'd0);
        chk("rst_ready", 64'(eu_ready_o), 64'd1);
        chk("exc_raised", 64'(eu_except_raised_o), 64'd0);
        chk("exc_code", 64'(eu_except_code_o), 64'd0);
        #20 rst_n_i = 1'b1;

        // Directed cases
        run_op(2'b01, 64'd100, 64'd7, 2'd2, 0);
        run_op(2'b11, 64'd100, 64'd7, 2'd1, 0);
        run_op(2'b00, -64'd100, 64'd7, 2'd3, 0);
        run_op(2'b10, -64'd100, 64'd7, 2'd0, 0);
        run_op(2'b10, 64'd100, -64'd7, 2'd1, 0);
        run_op(2'b01, 64'd5, 64'd0, 2'd2, 0);
        run_op(2'b10, 64'd5, 64'd0, 2'd3, 0);
        run_op(2'b00, MIN64, ONES, 2'd0, 0);
        run_op(2'b10, MIN64, ONES, 2'd1, 0);
        run_op(2'b01, MIN64, ONES, 2'd2, 0);
        run_op(2'b00, -64'd100, -64'd7, 2'd3, 0);
        chk("hex_div_neg", ref_div(2'b00, -64'd100, 64'd7), 64'hFFFF_FFFF_FFFF_FFF2);

        // Backpressure for 10 cycles in DONE
        run_op(2'b01, 64'd1000, 64'd33, 2'd3, 10);

        // Flush at CALC cycle 30, then a fresh op
        start_op(2'b01, 64'd123456, 64'd7, 2'd1, 1'b1);
        seen = 0;
        repeat (29) begin
            @(negedge clk_i);
            if (eu_valid_o) seen = 1;
        end
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        chk("flush_no_valid", 64'(seen), 64'd0);
        chk("flush_valid", 64'(eu_valid_o), 64'd0);
        chk("flush_idle", 64'(eu_ready_o), 64'd1);
        run_op(2'b01, 64'd9, 64'd3, 2'd2, 0);

        // Flush beats the result handshake in DONE
        start_op(2'b01, 64'd8, 64'd2, 2'd3, 1'b0);
        wait_cnt = 0;
        while (!eu_valid_o && wait_cnt < 200) begin @(negedge clk_i); wait_cnt++; end
        chk("flushdone_reached", 64'(eu_valid_o), 64'd1);
        flush_i = 1'b1; eu_ready_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        chk("flushdone_valid", 64'(eu_valid_o), 64'd0);
        chk("flushdone_idle", 64'(eu_ready_o), 64'd1);

        // Asynchronous reset mid-CALC
        start_op(2'b01, 64'd777, 64'd5, 2'd3, 1'b1);
        repeat (20) @(negedge clk_i);
        #2 rst_n_i = 1'b0;
        #1;
        chk("arst_calc_valid", 64'(eu_valid_o), 64'd0);
        chk("arst_calc_result", eu_result_o, 64'd0);
        chk("arst_calc_idx", 64'(eu_entry_idx_o), 64'd0);
        chk("arst_calc_ready", 64'(eu_ready_o), 64'd1);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        run_op(2'b01, 64'd9, 64'd3, 2'd1, 0);

        // Asynchronous reset while holding a result in DONE
        start_op(2'b11, 64'd50, 64'd6, 2'd2, 1'b0);
        wait_cnt = 0;
        while (!eu_valid_o && wait_cnt < 200) begin @(negedge clk_i); wait_cnt++; end
        chk("arst_done_reached", 64'(eu_valid_o), 64'd1);
        #2 rst_n_i = 1'b0;
        #1;
        chk("arst_done_valid", 64'(eu_valid_o), 64'd0);
        chk("arst_done_result", eu_result_o, 64'd0);
        chk("arst_done_idx", 64'(eu_entry_idx_o), 64'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        eu_ready_i = 1'b1;

        // Randomized operations
        for (int n = 0; n < 24; n++) begin
            rc = 2'($urandom_range(0, 3));
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: rb = 64'($urandom_range(1, 20));
                1: ra = 64'($urandom_range(0, 1000));
                2: begin ra = -64'($urandom_range(0, 1000)); rb = 64'($urandom_range(1, 50)); end
                3: rb = -64'($urandom_range(1, 50));
                4: rb = 64'd0;
                default: ;
            endcase
            run_op(rc, ra, rb, 2'($urandom_range(0, 3)), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
